// File: rtl/reg_file_lr_pkg.sv
// Shared CPU definitions: default widths, register index names and link-stack op decode.
package reg_file_lr_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 4;
    localparam int NUM_RD_DEF   = 2;
    localparam int LR_DEPTH_DEF = 4;

    typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} reg_idx_e;

    typedef enum logic [1:0] {LR_NOP, LR_PUSH, LR_POP, LR_SWAP} lr_op_e;

    // Push+pop on an empty stack degenerates to a plain push.
    function automatic lr_op_e lr_decode(input logic push, input logic pop, input logic empty);
        if (push && pop && !empty) return LR_SWAP;
        if (push)                  return LR_PUSH;
        if (pop)                   return LR_POP;
        return LR_NOP;
    endfunction

endpackage

// File: rtl/reg_file_lr_lr_stack.sv
// Circular link-register stack for nested CALL/RETURN with sticky overflow/underflow flags.
module lr_stack
    import reg_file_lr_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LR_DEPTH = LR_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    input  logic                          err_clr,
    output logic [DATA_W-1:0]             top,
    output logic [$clog2(LR_DEPTH+1)-1:0] count,
    output logic                          empty,
    output logic                          full,
    output logic                          ovf,
    output logic                          unf
);

    localparam int PTR_W = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;
    localparam int CNT_W = $clog2(LR_DEPTH + 1);

    logic [DATA_W-1:0] mem [LR_DEPTH];
    logic [PTR_W-1:0]  tp, tp_inc, tp_dec;
    lr_op_e            op;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tp_inc = (int'(tp) == LR_DEPTH - 1) ? '0 : tp + 1'b1;
        tp_dec = (tp == '0) ? PTR_W'(LR_DEPTH - 1) : tp - 1'b1;
        op     = lr_decode(push, pop, empty);
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(LR_DEPTH));
    assign top   = empty ? '0 : mem[tp];

    // NOTE: stack storage is reset too, because the architectural reset state is all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < LR_DEPTH; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments; the later flag set overrides the clear in the same cycle.
            if (err_clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            unique case (op)
                LR_PUSH: begin
                    mem[tp_inc] <= din;
                    tp          <= tp_inc;
                    if (full) ovf   <= 1'b1;
                    else      count <= count + 1'b1;
                end
                LR_POP: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        tp    <= tp_dec;
                        count <= count - 1'b1;
                    end
                end
                LR_SWAP: mem[tp] <= din;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_lr.sv
// Multi-port register file with two prioritised write ports, write-to-read bypass and link stack.
module reg_file_lr
    import reg_file_lr_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 0,
    parameter int LR_DEPTH = LR_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             wa0,
    input  logic [DATA_W-1:0]             wd0,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             wa1,
    input  logic [DATA_W-1:0]             wd1,
    input  logic [NUM_RD*ADDR_W-1:0]      ra,
    output logic [NUM_RD*DATA_W-1:0]      rd,
    input  logic                          lr_push,
    input  logic                          lr_pop,
    input  logic [DATA_W-1:0]             lr_din,
    output logic [DATA_W-1:0]             lr_top,
    output logic [$clog2(LR_DEPTH+1)-1:0] lr_count,
    output logic                          lr_empty,
    output logic                          lr_full,
    output logic                          lr_ovf,
    output logic                          lr_unf,
    input  logic                          err_clr
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // An address is live if it exists and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (we0 && addr_ok(wa0)) regs[wa0] <= wd0;
            if (we1 && addr_ok(wa1)) regs[wa1] <= wd1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;

        assign a = ra[i*ADDR_W +: ADDR_W];

        always_comb begin
            v = '0;
            if (addr_ok(a)) begin
                if (we1 && wa1 == a)      v = wd1;
                else if (we0 && wa0 == a) v = wd0;
                else                      v = regs[a];
            end
        end

        assign rd[i*DATA_W +: DATA_W] = v;
    end

    lr_stack #(
        .DATA_W   (DATA_W),
        .LR_DEPTH (LR_DEPTH)
    ) u_lr_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (lr_push),
        .pop     (lr_pop),
        .din     (lr_din),
        .err_clr (err_clr),
        .top     (lr_top),
        .count   (lr_count),
        .empty   (lr_empty),
        .full    (lr_full),
        .ovf     (lr_ovf),
        .unf     (lr_unf)
    );

endmodule
